// File: rtl/sm4_pkg.sv
// sm4_pkg: shared SM4 constants, FSM states, S-box and the T / T' transform helpers
package sm4_pkg;
  localparam int SM4_ROUNDS = 32;
  localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] KEXP = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [0:31][31:0] CK = {
    128'h00070e15_1c232a31_383f464d_545b6269,
    128'h70777e85_8c939aa1_a8afb6bd_c4cbd2d9,
    128'he0e7eef5_fc030a11_181f262d_343b4249,
    128'h50575e65_6c737a81_888f969d_a4abb2b9,
    128'hc0c7ced5_dce3eaf1_f8ff060d_141b2229,
    128'h30373e45_4c535a61_686f767d_848b9299,
    128'ha0a7aeb5_bcc3cad1_d8dfe6ed_f4fb0209,
    128'h10171e25_2c333a41_484f565d_646b7279
  };
  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction
  function automatic logic [31:0] lin(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction
  function automatic logic [31:0] lin_key(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction
endpackage

// File: rtl/sm4_key_exp.sv
// sm4_key_exp: combinational SM4 key-schedule step producing one round key
//   k: K0..K3 (K0 in [127:96]); ck: round constant; rk: new round key; k_next: shifted key state
module sm4_key_exp
  import sm4_pkg::*;
(
  input  logic [127:0] k,
  input  logic [31:0]  ck,
  output logic [31:0]  rk,
  output logic [127:0] k_next
);
  assign rk = k[127:96] ^ lin_key(tau(k[95:64] ^ k[63:32] ^ k[31:0] ^ ck));
  assign k_next = {k[95:0], rk};
endmodule

// File: rtl/sm4_rk_file.sv
// sm4_rk_file: 32x32 round-key store, synchronous write, asynchronous read
//   we/waddr/wdata: write port; raddr/rdata: combinational read port
module sm4_rk_file
  import sm4_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata
);
  logic [31:0] mem [SM4_ROUNDS];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sm4_round.sv
// sm4_round: combinational SM4 round, x_next = {X1,X2,X3, X0 ^ T(X1^X2^X3^rk)}
//   x: state words X0..X3 (X0 in [127:96]); rk: round key; x_next: shifted state
module sm4_round
  import sm4_pkg::*;
(
  input  logic [127:0] x,
  input  logic [31:0]  rk,
  output logic [127:0] x_next
);
  assign x_next = {x[95:0], x[127:96] ^ lin(tau(x[95:64] ^ x[63:32] ^ x[31:0] ^ rk))};
endmodule

// File: rtl/sm4_decrypt.sv
// sm4_decrypt: iterative SM4 block decryption with stored round keys
//   key_valid/key/key_ready: master-key load; in_valid/din/in_ready: ciphertext in;
//   out_valid/dout/out_ready: plaintext out; key_loaded: round keys are valid
module sm4_decrypt
  import sm4_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         in_valid,
  input  logic [127:0] din,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] dout,
  input  logic         out_ready,
  output logic         key_loaded
);
  logic [1:0] state;
  logic [4:0] cnt;
  logic [127:0] k, k_next, x, x_next;
  logic [31:0] rk, rk_rd;
  logic last;
  assign last = cnt == 5'(SM4_ROUNDS - 1);
  assign key_ready = state == IDLE;
  assign in_ready = key_ready && key_loaded && !key_valid;
  assign out_valid = state == DONE;
  sm4_key_exp u_kexp (.k(k), .ck(CK[cnt]), .rk(rk), .k_next(k_next));
  // decryption walks the key file backwards: ~cnt == 31-cnt
  sm4_rk_file u_rk (.clk(clk), .we(state == KEXP), .waddr(cnt), .wdata(rk), .raddr(~cnt), .rdata(rk_rd));
  sm4_round u_round (.x(x), .rk(rk_rd), .x_next(x_next));
  always_ff @(posedge clk) begin
    if (key_ready && key_valid) k <= key ^ FK;
    else if (state == KEXP) k <= k_next;
    if (in_ready && in_valid) x <= din;
    else if (state == ROUND) x <= x_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      key_loaded <= 1'b0;
      dout <= '0;
    end else begin
      case (state)
        IDLE:
          if (key_valid) begin
            state <= KEXP;
            cnt <= '0;
            key_loaded <= 1'b0;
          end else if (in_valid && key_loaded) begin
            state <= ROUND;
            cnt <= '0;
          end
        KEXP: begin
          cnt <= cnt + 5'd1;
          if (last) begin
            state <= IDLE;
            key_loaded <= 1'b1;
          end
        end
        ROUND: begin
          cnt <= cnt + 5'd1;
          if (last) begin
            state <= DONE;
            dout <= {x_next[31:0], x_next[63:32], x_next[95:64], x_next[127:96]};
          end
        end
        default:
          if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sm4_decrypt.sv
// tb_sm4_decrypt: self-checking bench for sm4_decrypt against a behavioural SM4 model
module tb_sm4_decrypt;
  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_CT = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] FK_M = 128'ha3b1bac656aa3350677d9197b27022dc;
  localparam logic [0:255][7:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_valid = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] din = '0;
  logic key_ready, in_ready, out_valid, key_loaded;
  logic [127:0] dout;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int key_acc = 0;
  int key_n = 0;
  int in_acc = 0;
  int in_n = 0;
  logic [31:0] m_rk [32];
  always #5 clk = ~clk;
  sm4_decrypt dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key), .key_ready(key_ready),
    .in_valid(in_valid), .din(din), .in_ready(in_ready), .out_valid(out_valid),
    .dout(dout), .out_ready(out_ready), .key_loaded(key_loaded)
  );
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (key_valid && key_ready) begin
      key_acc <= cyc + 1;
      key_n <= key_n + 1;
    end
    if (in_valid && in_ready) begin
      in_acc <= cyc + 1;
      in_n <= in_n + 1;
    end
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end
  function automatic logic [31:0] rol(input logic [31:0] w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction
  function automatic logic [31:0] tau_m(input logic [31:0] w);
    return {SB[w[31:24]], SB[w[23:16]], SB[w[15:8]], SB[w[7:0]]};
  endfunction
  function automatic logic [31:0] ck_m(input int i);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
    return r;
  endfunction
  function automatic void m_expand(input logic [127:0] mk);
    logic [31:0] kk [36];
    logic [127:0] s;
    logic [31:0] t;
    s = mk ^ FK_M;
    for (int i = 0; i < 4; i++) kk[i] = s[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      t = tau_m(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck_m(i));
      kk[i+4] = kk[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
      m_rk[i] = kk[i+4];
    end
  endfunction
  function automatic logic [127:0] m_crypt(input logic [127:0] blk, input bit dec);
    logic [31:0] xx [36];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) xx[i] = blk[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      t = tau_m(xx[i+1] ^ xx[i+2] ^ xx[i+3] ^ m_rk[dec ? 31 - i : i]);
      xx[i+4] = xx[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
    end
    return {xx[35], xx[34], xx[33], xx[32]};
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic send_key(input logic [127:0] k);
    int n0;
    n0 = key_n;
    key = k;
    key_valid = 1'b1;
    for (int i = 0; i < 100 && key_n == n0; i++) @(negedge clk);
    key_valid = 1'b0;
  endtask
  task automatic send_blk(input logic [127:0] d);
    int n0;
    n0 = in_n;
    din = d;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && in_n == n0; i++) @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_loaded();
    for (int i = 0; i < 100 && !key_loaded; i++) @(negedge clk);
  endtask
  task automatic wait_out();
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready: got %b want 1", key_ready); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (key_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_key_loaded: got %b want 0", key_loaded); end
    n_chk++; if (dout !== 128'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_no_key();
    int n0;
    bit seen;
    n0 = in_n;
    seen = 1'b0;
    din = rnd128();
    in_valid = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (in_ready !== 1'b0) seen = 1'b1;
    end
    in_valid = 1'b0;
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL no_key_in_ready: got high want 0"); end
    n_chk++; if (in_n !== n0) begin n_fail++; $display("FAIL no_key_accept: got %0d accepts want %0d", in_n - n0, 0); end
  endtask
  task automatic test_standard();
    out_ready = 1'b1;
    m_expand(STD_KEY);
    send_key(STD_KEY);
    wait_loaded();
    n_chk++; if (key_loaded !== 1'b1) begin n_fail++; $display("FAIL std_key_loaded: got %b want 1", key_loaded); end
    n_chk++; if (cyc - key_acc !== 32) begin n_fail++; $display("FAIL std_kexp_latency: got %0d want 32", cyc - key_acc); end
    n_chk++; if (dut.u_rk.mem[0] !== 32'hf12186f9) begin n_fail++; $display("FAIL std_rk0: got %h want f12186f9", dut.u_rk.mem[0]); end
    n_chk++; if (dut.u_rk.mem[31] !== 32'h9124a012) begin n_fail++; $display("FAIL std_rk31: got %h want 9124a012", dut.u_rk.mem[31]); end
    n_chk++; if (dut.u_rk.mem[17] !== m_rk[17]) begin n_fail++; $display("FAIL std_rk17: got %h want %h", dut.u_rk.mem[17], m_rk[17]); end
    send_blk(STD_CT);
    n_chk++; if (in_acc - key_acc !== 33) begin n_fail++; $display("FAIL std_first_accept: got edge %0d want 33", in_acc - key_acc); end
    wait_out();
    n_chk++; if (cyc - in_acc !== 32) begin n_fail++; $display("FAIL std_dec_latency: got %0d want 32", cyc - in_acc); end
    n_chk++; if (dout !== STD_KEY) begin n_fail++; $display("FAIL std_dout: got %h want %h", dout, STD_KEY); end
    @(negedge clk);
  endtask
  task automatic test_backpressure();
    logic [127:0] pt, d0;
    int n0;
    bit unstable, rdy;
    pt = rnd128();
    out_ready = 1'b0;
    send_blk(m_crypt(pt, 1'b0));
    wait_out();
    d0 = dout;
    n_chk++; if (dout !== pt) begin n_fail++; $display("FAIL bp_dout: got %h want %h", dout, pt); end
    n0 = in_n;
    unstable = 1'b0;
    rdy = 1'b0;
    din = rnd128();
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (dout !== d0 || out_valid !== 1'b1) unstable = 1'b1;
      if (in_ready !== 1'b0 || key_ready !== 1'b0) rdy = 1'b1;
    end
    n_chk++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL bp_stable: got change want stable %h", d0); end
    n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got high want 0"); end
    n_chk++; if (in_n !== n0) begin n_fail++; $display("FAIL bp_ignored: got %0d accepts want 0", in_n - n0); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || key_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got out_valid=%b key_ready=%b want 0/1", out_valid, key_ready); end
  endtask
  task automatic test_collision();
    logic [127:0] k2, pt, ct;
    int n0, k0;
    k2 = rnd128();
    pt = rnd128();
    m_expand(k2);
    ct = m_crypt(pt, 1'b0);
    n0 = in_n;
    k0 = key_n;
    key = k2;
    key_valid = 1'b1;
    din = ct;
    in_valid = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL col_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    key_valid = 1'b0;
    n_chk++; if (key_n - k0 !== 1 || in_n !== n0) begin n_fail++; $display("FAIL col_key_wins: got key=%0d blk=%0d want 1/0", key_n - k0, in_n - n0); end
    for (int i = 0; i < 100 && in_n == n0; i++) @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (in_acc - key_acc !== 33) begin n_fail++; $display("FAIL col_accept_edge: got %0d want 33", in_acc - key_acc); end
    wait_out();
    n_chk++; if (dout !== pt) begin n_fail++; $display("FAIL col_dout: got %h want %h", dout, pt); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    send_blk(rnd128());
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if (key_ready !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got key_ready=%b in_ready=%b want 1/0", key_ready, in_ready); end
    n_chk++; if (out_valid !== 1'b0 || dout !== 128'h0) begin n_fail++; $display("FAIL mid_out: got out_valid=%b dout=%h want 0/0", out_valid, dout); end
    n_chk++; if (key_loaded !== 1'b0) begin n_fail++; $display("FAIL mid_key_loaded: got %b want 0", key_loaded); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_expand(STD_KEY);
    send_key(STD_KEY);
    wait_loaded();
    send_blk(STD_CT);
    wait_out();
    n_chk++; if (dout !== STD_KEY) begin n_fail++; $display("FAIL mid_reload_dout: got %h want %h", dout, STD_KEY); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back();
    logic [127:0] p1, p2;
    int n0, a1;
    p1 = rnd128();
    p2 = rnd128();
    out_ready = 1'b1;
    n0 = in_n;
    din = m_crypt(p1, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 100 && in_n == n0; i++) @(negedge clk);
    a1 = in_acc;
    din = m_crypt(p2, 1'b0);
    wait_out();
    n_chk++; if (dout !== p1) begin n_fail++; $display("FAIL b2b_dout1: got %h want %h", dout, p1); end
    for (int i = 0; i < 100 && in_n != n0 + 2; i++) @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (in_acc - a1 !== 34) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 34", in_acc - a1); end
    wait_out();
    n_chk++; if (dout !== p2) begin n_fail++; $display("FAIL b2b_dout2: got %h want %h", dout, p2); end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_no_key();
    test_standard();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sm4_decrypt.md
# sm4_decrypt

Iterative SM4 block decryption engine: loads a 128-bit key, expands and stores the 32 round keys, then decrypts one 128-bit ciphertext block per request by applying the SM4 round function with the round keys in reverse order. It is the decrypt-side counterpart to the existing combinational round and key-schedule logic, and wraps that logic in a key store, a round counter and valid/ready handshakes. It sits between a ciphertext source and a plaintext sink.

## Interface
- No parameters; all sizes are fixed by SM4.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  `key` is presented.
- `key`  in  128  master key MK, MK0 in [127:96].
- `key_ready`  out  1  key accepted when `key_valid && key_ready`.
- `in_valid`  in  1  `din` is presented.
- `din`  in  128  ciphertext, X0 in [127:96].
- `in_ready`  out  1  block accepted when `in_valid && in_ready`.
- `out_valid`  out  1  `dout` holds the plaintext.
- `dout`  out  128  plaintext, Y0 in [127:96].
- `out_ready`  in  1  sink takes `dout` when `out_valid && out_ready`.
- `key_loaded`  out  1  a complete round-key set is stored.

## Operation
- FSM states: IDLE, KEXP, ROUND, DONE. A 5-bit counter `cnt` is used in KEXP and ROUND.
- `key_ready = (state==IDLE)`.
- `in_ready = (state==IDLE) && key_loaded && !key_valid`. If a key and a block are offered in the same cycle, the key wins.
- **Key accept** (IDLE): K <= key ^ FK, with FK = a3b1bac6_56aa3350_677d9197_b27022dc. Then `key_loaded` <= 0, `cnt` <= 0, state -> KEXP.
- **KEXP**, each cycle:
  - rk = K0 ^ T'(K1^K2^K3^CK[cnt]).
  - rk_file[cnt] <= rk.
  - K <= {K1,K2,K3,rk}.
  - `cnt` increments.
  - When `cnt==31`: state -> IDLE, `key_loaded` <= 1.
- **Block accept** (IDLE): X <= din, `cnt` <= 0, state -> ROUND.
- **ROUND**, each cycle:
  - X <= {X1,X2,X3, X0 ^ T(X1^X2^X3^rk_file[31-cnt])}.
  - `cnt` increments.
  - When `cnt==31`: state -> DONE.
- **DONE**:
  - `out_valid` = 1.
  - `dout` = reverse-word of X, i.e. {X3,X2,X1,X0}. It is stable while `out_valid && !out_ready`.
  - On `out_ready`: state -> IDLE.
- Once loaded, the round keys persist across blocks until a new key is accepted.
- `cnt` wraps 31 -> 0; it is only meaningful in KEXP and ROUND.
- Inputs offered outside IDLE are ignored: `key_ready` and `in_ready` are low there.
- T and T' use the standard SM4 S-box and the L / L' linear transforms.

## Timing
- Reset values:
  - state = IDLE, `key_loaded` = 0, `out_valid` = 0, `dout` = 0, `key_ready` = 1, `in_ready` = 0, `cnt` = 0.
  - rk_file and K are not reset.
- Reset mid-operation aborts KEXP, ROUND or DONE. Stored keys are invalidated (`key_loaded` = 0) and must be reloaded.
- Key expansion:
  - accept edge e0; round keys are written on edges e1..e32.
  - `key_loaded` = 1 and `key_ready` = 1 after e32.
  - The first block can be accepted on e33.
- Decryption:
  - accept edge e0; rounds are computed on edges e1..e32.
  - `out_valid` = 1 after e32, i.e. a latency of 32 cycles.
  - If `out_ready` is already high, IDLE is reached after e33 and the next accept can occur on e34. Minimum period is 34 cycles per block.
- All outputs are registered, or decoded from registered state only. There is no combinational path from any input to any output, except the `key_valid` term in `in_ready`.

## Structure
- Shared package `sm4_pkg`:
  - FK constant.
  - `SM4_ROUNDS` = 32.
  - State enumeration.
  - The CK table, moved here so that key expansion and this block share one copy.
- The existing round-function module and key-expansion module are instantiated once each. Both are combinational.
- One new sub-module, `sm4_rk_file`: 32×32 register file with one synchronous write port and one asynchronous read port.

## Test plan
- **Standard vector.** Load key 0123456789abcdeffedcba9876543210. Then:
  - rk_file[0] = f12186f9 and rk_file[31] = 9124a012.
  - `key_loaded` rises 32 cycles after the key accept.
  - Decrypting din = 681edf34d206965e86b3e94f536e4246 gives dout = 0123456789abcdeffedcba9876543210 exactly 32 cycles after the block accept.
- **Backpressure.** Hold `out_ready` = 0 for 10 cycles in DONE. Then:
  - `dout` and `out_valid` stay stable.
  - `in_ready` stays 0.
  - The release cycle returns the FSM to IDLE.
- **Key/data collision.** Assert `key_valid` and `in_valid` together in IDLE. Then:
  - Only the key is taken and `in_ready` = 0.
  - The block is accepted after KEXP completes and decrypts under the new key.
- **No key.** Assert `in_valid` after reset without loading a key. `in_ready` stays 0 indefinitely.
- **Reset mid-round.** Assert `rst` at round 15. Then:
  - All outputs return to their reset values and `key_loaded` = 0.
  - After a key reload, the standard vector decrypts correctly.
- **Back-to-back blocks.** Decrypt two blocks under one key load with `out_ready` tied high. Then:
  - Both plaintexts are correct.
  - The accepts are spaced 34 cycles apart.
